// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default sizes,
// address width derivation and the hardwired-zero register address.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int X0_ADDR  = 0;

  // Address width for a file of nreg registers; never narrower than one bit.
  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/rf_wr_select.sv
// Per-read-port lookup across all write ports. Reports whether any write
// port targets the read address this cycle, the data of the highest-index
// such port, and whether any matching write also clears the pending bit.
module rf_wr_select
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = addr_width(NREG_DEF),
  parameter int NWR  = 1
) (
  input  logic [AW-1:0]       addr,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  output logic                hit,
  output logic [XLEN-1:0]     data,
  output logic                clr_hit
);

  // Scan upward so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit     = 1'b0;
    data    = '0;
    clr_hit = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[j*XLEN +: XLEN];
        if (wr_clr[j]) begin
          clr_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register pending scoreboard.
// Decode reads operands and reserves destinations; writeback commits data
// and optionally clears reservations. Register 0 reads as zero and ignores
// writes, clears and reservations.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                any_busy
);

  localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;

  // Data storage: ports commit in ascending order so the highest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != X0)) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: clears applied first, then a reservation
  // overrides, since a newly issued producer must keep the register busy.
  always_comb begin
    pend_next = pend;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]) begin
        pend_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) begin
      pend_next[rsv_addr] = 1'b1;
    end
    pend_next[X0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  assign any_busy = |pend;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic            clr_hit;
    logic [XLEN-1:0] bp_data;

    assign ra = rd_addr[k*AW +: AW];

    rf_wr_select #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_sel (
      .addr    (ra),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_clr  (wr_clr),
      .hit     (hit),
      .data    (bp_data),
      .clr_hit (clr_hit)
    );

    assign rd_data[k*XLEN +: XLEN] = (ra == X0)                ? '0      :
                                     ((BYPASS != 0) && hit)    ? bp_data :
                                                                 regs[ra];

    assign rd_busy[k] = (ra != X0) && pend[ra] && !((BYPASS != 0) && clr_hit);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with a per-register pending scoreboard. It replaces the fixed 2-read/1-write file in the core datapath. Decode reads operands through N read ports and reserves destination registers. Writeback retires results through M write ports and clears reservations. Optional write-to-read bypass removes the one-cycle writeback hazard.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREG), register address width
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored state

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NRD  port k's register has an outstanding reservation
wr_en  in  NWR  write strobe per write port
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
wr_clr  in  NWR  write also clears the pending bit of wr_addr
rsv_en  in  1  reserve destination register
rsv_addr  in  AW  register to mark pending
any_busy  out  1  OR of all pending bits (drain/fence indicator)

Behaviour:
- Reset (async, rst_n=0): all NREG registers = 0, all pending bits = 0. rd_data then reads 0 and rd_busy/any_busy read 0. Reset mid-operation discards all writes and reservations in flight.
- Register 0 is hardwired: reads return 0, rd_busy=0 for address 0. Writes, clears and reservations to address 0 are ignored.
- Reads are combinational, zero latency.
- BYPASS=1: if any wr_en[j] targets the read address this cycle, rd_data returns the highest-index matching wr_data[j]. Otherwise rd_data returns the stored value.
- BYPASS=0: reads always return the stored value. The write becomes visible the cycle after the edge.
- Writes commit at the rising edge. Multiple write ports to the same address: highest port index wins. Non-matching ports commit independently.
- Pending bit p[a], next state:
  - set if rsv_en && rsv_addr==a;
  - else cleared if any wr_en[j] && wr_clr[j] && wr_addr[j]==a;
  - else held.
  Reserve beats clear in the same cycle, because a new producer has been issued.
- A wr_en without wr_clr updates data only; the pending bit is unchanged. This covers non-final partial writes.
- rd_busy[k]:
  - BYPASS=1: p[rd_addr[k]] && !(same-cycle clearing write to that address).
  - BYPASS=0: p[rd_addr[k]] as stored.
  - A same-cycle rsv_en does not affect rd_busy until the next cycle.
- A reservation of an already-pending register is legal; the bit stays 1. No counting is done.
- Clearing a non-pending register is legal and has no effect on the pending bit.
- any_busy is a registered-state OR, and is valid the cycle after the last set/clear.
- Address values >= NREG are impossible (NREG is a power of two).

Decomposition:
- Shared package regfile_pkg holds XLEN default, NREG default, AW derivation, and the X0 address constant.
- Sub-module rf_wr_select, one instance per read port: priority-select of the highest-index matching write port, outputting hit and data. The bypass mux and the busy-clear term both use it.
- Storage and scoreboard stay in the top level.

Test Plan:
- Reset: preload regs, pulse rst_n low mid-cycle -> all rd_data=0, rd_busy=0, any_busy=0 immediately, without waiting for a clock edge.
- x0: write 0xDEADBEEF to addr 0, rsv addr 0 -> rd_data(0)=0, rd_busy=0, any_busy=0.
- Bypass: BYPASS=1, write 0x12345678 to r5 while reading r5 on port 1 -> rd_data=0x12345678 same cycle. With BYPASS=0, the old value appears that cycle and 0x12345678 the next cycle.
- Write collision: NWR=2, both ports write r7, 0x1 on port 0 and 0x2 on port 1 -> r7=0x2. Bypassed read of r7 returns 0x2.
- Scoreboard: rsv r3 -> next cycle rd_busy=1 and any_busy=1. Write r3 with wr_clr=0 -> still busy. Write r3=0xA5 with wr_clr=1 -> same-cycle rd_busy=0 (BYPASS=1), and p[3]=0 after the edge.
- Reserve/clear race: same cycle rsv r9 and clearing write to r9 -> r9 data updated, p[9]=1 afterwards.
